memory_port_arbiter: RTL and testbench

//   Shares the core's single memory port between two requesters: instruction fetch (pc path) and the load/store path of execute.

---
 rtl/memory_arbiter_pkg.sv | 14 +
 rtl/memory_latency_timer.sv | 29 ++
 rtl/memory_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and owner codes.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arbiter_state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/memory_latency_timer.sv
// Loadable down-counter timing the memory read latency; o_done marks the final
// WAIT cycle, when the count has reached 1.
module memory_latency_timer #(
  parameter int MEMORY_LATENCY = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_enable,
  output logic o_done
);

  localparam int CW = $clog2(MEMORY_LATENCY + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(MEMORY_LATENCY);
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done = (r_count == CW'(1));

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// Optional fetch anti-starvation is built when ARBITER_FAIRNESS_EN is defined.
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int MEMORY_LATENCY   = 1,
  parameter int STARVATION_LIMIT = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_fetch_request_valid,
  output logic                      o_fetch_request_ready,
  input  logic [ADDRESS_WIDTH-1:0]  i_fetch_address,
  output logic                      o_fetch_response_valid,
  output logic [DATA_WIDTH-1:0]     o_fetch_response_data,
  input  logic                      i_data_request_valid,
  output logic                      o_data_request_ready,
  input  logic                      i_data_request_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_data_address,
  input  logic [DATA_WIDTH-1:0]     i_data_write_value,
  input  logic [DATA_WIDTH/8-1:0]   i_data_write_mask,
  output logic                      o_data_response_valid,
  output logic [DATA_WIDTH-1:0]     o_data_response_data,
  output logic                      o_memory_read_enable,
  output logic                      o_memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0]  o_memory_address,
  output logic [DATA_WIDTH-1:0]     o_memory_write_value,
  output logic [DATA_WIDTH/8-1:0]   o_memory_write_mask,
  input  logic [DATA_WIDTH-1:0]     i_memory_read_value
);

  localparam int MW = DATA_WIDTH / 8;

  if (MEMORY_LATENCY < 1 || STARVATION_LIMIT < 1) begin : g_bad_param
    $error("memory_port_arbiter: MEMORY_LATENCY and STARVATION_LIMIT must be >= 1");
  end

  arbiter_state_t r_state;
  arbiter_state_t w_state_next;

  logic r_owner;
  logic r_write;

  logic                     r_mem_read_enable;
  logic                     r_mem_write_enable;
  logic [ADDRESS_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0]    r_mem_write_value;
  logic [MW-1:0]            r_mem_write_mask;

  logic [DATA_WIDTH-1:0] r_fetch_read_data;
  logic [DATA_WIDTH-1:0] r_data_read_data;

  logic w_idle;
  logic w_fetch_priority;
  logic w_grant_data;
  logic w_grant_fetch;
  logic w_accept;
  logic w_accept_write;
  logic w_timer_load;
  logic w_timer_enable;
  logic w_timer_done;
  logic w_capture;

  // Readies are held low during reset even though the state already reads IDLE.
  assign w_idle        = (r_state == IDLE) && !i_reset;
  assign w_grant_data  = i_data_request_valid && !(w_fetch_priority && i_fetch_request_valid);
  assign w_grant_fetch = i_fetch_request_valid && !w_grant_data;

  assign o_data_request_ready  = w_idle && w_grant_data;
  assign o_fetch_request_ready = w_idle && w_grant_fetch;
  assign w_accept              = o_data_request_ready || o_fetch_request_ready;
  assign w_accept_write        = w_grant_data && i_data_request_write;

`ifdef ARBITER_FAIRNESS_EN
  localparam int SCW = $clog2(STARVATION_LIMIT + 1);

  logic [SCW-1:0] r_starve_count;

  assign w_fetch_priority = (r_starve_count == SCW'(STARVATION_LIMIT));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_starve_count <= '0;
    end else if (w_accept) begin
      if (!w_grant_data) begin
        r_starve_count <= '0;
      end else if (i_fetch_request_valid && !w_fetch_priority) begin
        r_starve_count <= r_starve_count + SCW'(1);
      end
    end
  end
`else
  assign w_fetch_priority = 1'b0;
`endif

  memory_latency_timer #(
    .MEMORY_LATENCY(MEMORY_LATENCY)
  ) u_latency_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_timer_load),
    .i_enable(w_timer_enable),
    .o_done  (w_timer_done)
  );

  always_comb begin
    w_state_next   = r_state;
    w_timer_load   = 1'b0;
    w_timer_enable = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = ISSUE;
      end
      ISSUE: begin
        w_timer_load = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        w_timer_enable = 1'b1;
        if (w_timer_done) begin
          w_capture    = 1'b1;
          w_state_next = RESPOND;
        end
      end
      RESPOND: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_owner <= OWNER_FETCH;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_owner <= w_grant_data ? OWNER_DATA : OWNER_FETCH;
        r_write <= w_accept_write;
      end
    end
  end

  // The command registers load on the accept edge so they are live only in ISSUE.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mem_read_enable  <= 1'b0;
      r_mem_write_enable <= 1'b0;
      r_mem_address      <= '0;
      r_mem_write_value  <= '0;
      r_mem_write_mask   <= '0;
    end else if (w_accept) begin
      r_mem_read_enable  <= !w_accept_write;
      r_mem_write_enable <= w_accept_write;
      r_mem_address      <= w_grant_data ? i_data_address : i_fetch_address;
      r_mem_write_value  <= w_accept_write ? i_data_write_value : '0;
      r_mem_write_mask   <= w_accept_write ? i_data_write_mask : '0;
    end else begin
      r_mem_read_enable  <= 1'b0;
      r_mem_write_enable <= 1'b0;
      r_mem_address      <= '0;
      r_mem_write_value  <= '0;
      r_mem_write_mask   <= '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_read_data <= '0;
      r_data_read_data  <= '0;
    end else if (w_capture) begin
      if (r_owner == OWNER_DATA) begin
        r_data_read_data <= r_write ? '0 : i_memory_read_value;
      end else begin
        r_fetch_read_data <= i_memory_read_value;
      end
    end
  end

  assign o_fetch_response_valid = (r_state == RESPOND) && (r_owner == OWNER_FETCH);
  assign o_data_response_valid  = (r_state == RESPOND) && (r_owner == OWNER_DATA);
  assign o_fetch_response_data  = r_fetch_read_data;
  assign o_data_response_data   = r_data_read_data;

  assign o_memory_read_enable  = r_mem_read_enable;
  assign o_memory_write_enable = r_mem_write_enable;
  assign o_memory_address      = r_mem_address;
  assign o_memory_write_value  = r_mem_write_value;
  assign o_memory_write_mask   = r_mem_write_mask;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench: u_dut1 (latency 1, starvation limit 2) and u_dut3 (latency 3)
// share request stimulus; each has its own memory read data source.
module tb_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0;
  logic [31:0] f_addr = '0;
  logic        d_valid = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wval = '0;
  logic [3:0]  d_wmask = '0;

  logic        f_ready1, fresp_v1, d_ready1, dresp_v1, mem_re1, mem_we1;
  logic [31:0] fresp_d1, dresp_d1, mem_addr1, mem_wv1, rv1;
  logic [3:0]  mem_wm1;
  logic        f_ready3, fresp_v3, d_ready3, dresp_v3, mem_re3, mem_we3;
  logic [31:0] fresp_d3, dresp_d3, mem_addr3, mem_wv3;
  logic [31:0] rv3 = 32'hBADBAD00;
  logic [3:0]  mem_wm3;
  logic [31:0] hold1 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00500093;
      32'h14:  return 32'h00A00113;
      32'h40:  return 32'h12345678;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  // Latency-1 memory: data for the last commanded read is valid from the next cycle on.
  always @(posedge clk) if (mem_re1) hold1 <= mem_addr1;
  assign rv1 = mem_lookup(hold1);

  memory_port_arbiter #(.MEMORY_LATENCY(1), .STARVATION_LIMIT(2)) u_dut1 (
    .i_clock(clk), .i_reset(rst),
    .i_fetch_request_valid(f_valid), .o_fetch_request_ready(f_ready1), .i_fetch_address(f_addr),
    .o_fetch_response_valid(fresp_v1), .o_fetch_response_data(fresp_d1),
    .i_data_request_valid(d_valid), .o_data_request_ready(d_ready1), .i_data_request_write(d_write),
    .i_data_address(d_addr), .i_data_write_value(d_wval), .i_data_write_mask(d_wmask),
    .o_data_response_valid(dresp_v1), .o_data_response_data(dresp_d1),
    .o_memory_read_enable(mem_re1), .o_memory_write_enable(mem_we1), .o_memory_address(mem_addr1),
    .o_memory_write_value(mem_wv1), .o_memory_write_mask(mem_wm1), .i_memory_read_value(rv1)
  );

  memory_port_arbiter #(.MEMORY_LATENCY(3)) u_dut3 (
    .i_clock(clk), .i_reset(rst),
    .i_fetch_request_valid(f_valid), .o_fetch_request_ready(f_ready3), .i_fetch_address(f_addr),
    .o_fetch_response_valid(fresp_v3), .o_fetch_response_data(fresp_d3),
    .i_data_request_valid(d_valid), .o_data_request_ready(d_ready3), .i_data_request_write(d_write),
    .i_data_address(d_addr), .i_data_write_value(d_wval), .i_data_write_mask(d_wmask),
    .o_data_response_valid(dresp_v3), .o_data_response_data(dresp_d3),
    .o_memory_read_enable(mem_re3), .o_memory_write_enable(mem_we3), .o_memory_address(mem_addr3),
    .o_memory_write_value(mem_wv3), .o_memory_write_mask(mem_wm3), .i_memory_read_value(rv3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [5:0] exp_order;

  initial begin
`ifdef ARBITER_FAIRNESS_EN
    exp_order = 6'b011011;
`else
    exp_order = 6'b111111;
`endif
    // Reset state
    tick();
    check("rst_mem_re", mem_re1, 0);
    check("rst_mem_addr", mem_addr1, 0);
    check("rst_fresp_v", fresp_v1, 0);
    check("rst_dresp_d", dresp_d1, 0);
    tick();
    rst = 1'b0;

    // Fetch-only read at 0x10
    f_valid = 1; f_addr = 32'h10; #1;
    check("f_t0_fready", f_ready1, 1);
    check("f_t0_dready", d_ready1, 0);
    tick(); f_valid = 0;
    check("f_t1_mem_re", mem_re1, 1);
    check("f_t1_addr", mem_addr1, 32'h10);
    check("f_t1_mem_we", mem_we1, 0);
    tick();
    check("f_t2_mem_re", mem_re1, 0);
    check("f_t2_fresp_v", fresp_v1, 0);
    tick();
    check("f_t3_fresp_v", fresp_v1, 1);
    check("f_t3_fresp_d", fresp_d1, 32'h00500093);
    check("f_t3_dresp_v", dresp_v1, 0);
    tick();
    check("f_t4_fresp_v", fresp_v1, 0);
    f_valid = 1; #1;
    check("f_t4_fready", f_ready1, 1);
    f_valid = 0; #1;

    // Both valid: data first, then fetch
    tick();
    d_valid = 1; d_write = 0; d_addr = 32'h40; f_valid = 1; f_addr = 32'h14; #1;
    check("b_t0_dready", d_ready1, 1);
    check("b_t0_fready", f_ready1, 0);
    tick(); d_valid = 0;
    check("b_t1_addr", mem_addr1, 32'h40);
    tick(); tick();
    check("b_t3_dresp_v", dresp_v1, 1);
    check("b_t3_dresp_d", dresp_d1, 32'h12345678);
    check("b_t3_fresp_v", fresp_v1, 0);
    tick();
    check("b_t4_fready", f_ready1, 1);
    tick(); f_valid = 0;
    check("b_t5_addr", mem_addr1, 32'h14);
    tick(); tick();
    check("b_t7_fresp_v", fresp_v1, 1);
    check("b_t7_fresp_d", fresp_d1, 32'h00A00113);
    tick();

    // Store 0xDEADBEEF to 0x80 with mask 0011
    d_valid = 1; d_write = 1; d_addr = 32'h80; d_wval = 32'hDEADBEEF; d_wmask = 4'b0011; #1;
    check("s_t0_dready", d_ready1, 1);
    tick(); d_valid = 0; d_write = 0;
    check("s_t1_mem_we", mem_we1, 1);
    check("s_t1_mem_re", mem_re1, 0);
    check("s_t1_mask", mem_wm1, 4'b0011);
    check("s_t1_value", mem_wv1, 32'hDEADBEEF);
    check("s_t1_addr", mem_addr1, 32'h80);
    tick();
    check("s_t2_mem_we", mem_we1, 0);
    check("s_t2_mem_re", mem_re1, 0);
    tick();
    check("s_t3_dresp_v", dresp_v1, 1);
    check("s_t3_dresp_d", dresp_d1, 0);
    tick();

    // Reset while in WAIT
    f_valid = 1; f_addr = 32'h10; #1;
    tick(); f_valid = 0;
    tick();
    rst = 1; f_valid = 1; f_addr = 32'h14; #1;
    check("r_mem_re", mem_re1, 0);
    check("r_fready", f_ready1, 0);
    check("r_fresp_d", fresp_d1, 0);
    tick();
    check("r_t3_fresp_v", fresp_v1, 0);
    tick();
    rst = 0; #1;
    check("r_rel_fready", f_ready1, 1);
    check("r_rel_fresp_v", fresp_v1, 0);
    tick(); f_valid = 0;
    tick(); tick();
    check("r_new_fresp_v", fresp_v1, 1);
    check("r_new_fresp_d", fresp_d1, 32'h00A00113);

    // Latency 3 on u_dut3
    reset_pulse();
    f_valid = 1; f_addr = 32'h20; #1;
    check("l3_t0_fready", f_ready3, 1);
    tick(); f_valid = 0;
    check("l3_t1_mem_re", mem_re3, 1);
    check("l3_t1_addr", mem_addr3, 32'h20);
    tick(); tick(); tick();
    rv3 = 32'hCAFEF00D;
    check("l3_t4_fresp_v", fresp_v3, 0);
    tick();
    rv3 = 32'hBADBAD00;
    check("l3_t5_fresp_v", fresp_v3, 1);
    check("l3_t5_fresp_d", fresp_d3, 32'hCAFEF00D);
    tick();
    check("l3_t6_fresp_v", fresp_v3, 0);

    // Grant order with both requesters valid continuously
    reset_pulse();
    d_valid = 1; d_write = 0; d_addr = 32'h40; f_valid = 1; f_addr = 32'h14; #1;
    for (int g = 0; g < 6; g++) begin
      int waited = 0;
      while (!(f_ready1 || d_ready1) && waited < 20) begin
        tick();
        waited++;
      end
      if (waited >= 20) begin
        check("grant_timeout", 0, 1);
      end else begin
        $display("grant %0d -> %s", g, d_ready1 ? "data" : "fetch");
        check($sformatf("grant%0d_is_data", g), d_ready1, exp_order[g]);
      end
      tick();
    end
    d_valid = 0; f_valid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
